// File: rtl/sha256_ctrl.sv
// rtl/sha256_ctrl.sv - SHA-256 block sequencing controller
//
// Owns hash state H0..H7, loads the initial hash constants at the start of a
// message, steps the external round datapath through 64 rounds per block,
// performs the feed-forward addition and presents the digest on a
// valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   blk_valid/blk_ready      block handshake; blk_first/blk_last sampled at accept
//   wv_load                  datapath loads a..h from hash_state
//   round_en, round_idx      datapath round strobe and round number (K[t], W[t])
//   wv_in                    datapath working variables {a..h}, a in [255:224]
//   hash_state, digest       {H0..H7}, H0 in [255:224]
//   digest_valid/ready       digest handshake
//   busy                     high whenever not IDLE
module sha256_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         blk_ready,
  output logic         wv_load,
  output logic         round_en,
  output logic [5:0]   round_idx,
  input  logic [255:0] wv_in,
  output logic [255:0] hash_state,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    UPDATE,
    DONE
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q;
  logic         in_msg_q;
  logic         last_q;
  logic [255:0] h_q;
  logic         accept;

  assign accept = (state_q == IDLE) && blk_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (blk_valid) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (cnt_q == LAST_ROUND) state_d = UPDATE;
      UPDATE:  state_d = last_q ? DONE : IDLE;
      DONE:    if (digest_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs are pure decodes of registered state.
  assign blk_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign wv_load      = (state_q == LOAD);
  assign round_en     = (state_q == ROUND);
  assign round_idx    = (state_q == ROUND) ? cnt_q : 6'd0;
  assign digest_valid = (state_q == DONE);
  assign hash_state   = h_q;
  assign digest       = h_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 6'd0;
      in_msg_q <= 1'b0;
      last_q   <= 1'b0;
      h_q      <= '0;
    end else begin
      if (accept) begin
        last_q   <= blk_last;
        in_msg_q <= 1'b1;
        // A first block always restarts the hash; so does a block that
        // arrives with no message in progress (e.g. after reset).
        if (blk_first || !in_msg_q) begin
          h_q <= H_INIT;
        end
      end

      if (state_q == LOAD) begin
        cnt_q <= 6'd0;
      end else if (state_q == ROUND) begin
        // Natural 6-bit wrap takes the counter back to 0 after round 63.
        cnt_q <= cnt_q + 6'd1;
      end

      if (state_q == UPDATE) begin
        for (int i = 0; i < 8; i++) begin
          h_q[255 - 32*i -: 32] <= h_q[255 - 32*i -: 32] + wv_in[255 - 32*i -: 32];
        end
        if (last_q) begin
          in_msg_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_ctrl.sv
// tb/tb_sha256_ctrl.sv - self-checking bench for sha256_ctrl
module tb_sha256_ctrl;

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIGEST = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid, blk_first, blk_last, blk_ready;
  logic         wv_load, round_en;
  logic [5:0]   round_idx;
  logic [255:0] wv_in, hash_state, digest;
  logic         digest_valid, digest_ready, busy;

  sha256_ctrl dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last), .blk_ready(blk_ready),
    .wv_load(wv_load), .round_en(round_en), .round_idx(round_idx), .wv_in(wv_in),
    .hash_state(hash_state), .digest(digest), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference round datapath (used for the "abc" vector) or a constant stub.
  logic         use_model;
  logic [31:0]  stub_word;
  logic [255:0] wv_m;
  logic [31:0]  w [0:63];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] do_round(input logic [255:0] s, input logic [31:0] kt, input logic [31:0] wt);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kt + wt;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  always @(posedge clk) begin
    if (wv_load) wv_m <= hash_state;
    else if (round_en) wv_m <= do_round(wv_m, K[round_idx], w[round_idx]);
  end

  assign wv_in = use_model ? wv_m : {8{stub_word}};

  int tests = 0;
  int fails = 0;
  logic [255:0] sb [$];
  logic [255:0] last_exp;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one block through the whole 67-cycle sequence, checking every
  // cycle; h1 is the hash state expected right after the accept edge.
  task automatic run_block(input bit first, input bit last, input logic [255:0] h1, input logic [255:0] exp);
    blk_valid = 1'b1; blk_first = first; blk_last = last;
    check("blk_ready_before_accept", 256'(blk_ready), 256'(1));
    if (last) sb.push_back(exp);
    tick();
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    check("load_cycle {wv_load,round_en,busy,blk_ready}", 256'({wv_load, round_en, busy, blk_ready}), 256'(4'b1010));
    check("h_after_accept", hash_state, h1);
    for (int i = 0; i < 64; i++) begin
      tick();
      check($sformatf("round %0d {round_en,wv_load,round_idx}", i),
            256'({round_en, wv_load, round_idx}), 256'({2'b10, 6'(i)}));
    end
    tick();
    check("update_cycle {round_en,wv_load,busy,blk_ready,digest_valid,round_idx}",
          256'({round_en, wv_load, busy, blk_ready, digest_valid, round_idx}), 256'({5'b00100, 6'd0}));
    tick();
    if (last) begin
      check("digest_valid_at_T67", 256'({digest_valid, blk_ready}), 256'(2'b10));
      if (sb.size() == 0) begin
        check("scoreboard_nonempty", 256'(0), 256'(1));
      end else begin
        last_exp = sb.pop_front();
        check("digest", digest, last_exp);
        check("hash_state_eq_digest", hash_state, last_exp);
      end
    end else begin
      check("idle_after_nonlast {blk_ready,digest_valid,busy}", 256'({blk_ready, digest_valid, busy}), 256'(3'b100));
    end
  endtask

  task automatic take_digest(input int hold);
    for (int i = 0; i < hold; i++) begin
      check($sformatf("done_hold %0d {digest_valid,blk_ready}", i), 256'({digest_valid, blk_ready}), 256'(2'b10));
      check($sformatf("done_hold %0d digest", i), digest, last_exp);
      tick();
    end
    digest_ready = 1'b1;
    check("done_before_ready_edge", 256'(digest_valid), 256'(1));
    tick();
    digest_ready = 1'b0;
    check("idle_after_digest {digest_valid,blk_ready,busy}", 256'({digest_valid, blk_ready, busy}), 256'(3'b010));
  endtask

  initial begin
    // Message schedule for the padded single-block "abc" message.
    for (int i = 0; i < 16; i++) w[i] = 32'h0;
    w[0]  = 32'h61626380;
    w[15] = 32'h00000018;
    for (int i = 16; i < 64; i++) begin
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end

    rst = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    digest_ready = 1'b0; use_model = 1'b0; stub_word = 32'h0;
    last_exp = '0;
    #12;
    check("reset {blk_ready,busy,wv_load,round_en,digest_valid}",
          256'({blk_ready, busy, wv_load, round_en, digest_valid}), 256'(5'b10000));
    check("reset round_idx", 256'(round_idx), 256'(0));
    check("reset hash_state", hash_state, 256'(0));
    tick();
    rst = 1'b0;
    tick();

    // Single block, stub zero: digest is the initial constants.
    stub_word = 32'h0;
    run_block(1'b1, 1'b1, H_INIT, H_INIT);
    take_digest(0);

    // Single block, all-ones stub: every word wraps.
    stub_word = 32'hffffffff;
    run_block(1'b1, 1'b1, H_INIT, add_words(H_INIT, {8{32'hffffffff}}));
    check("wrap_h0", 256'(last_exp[255:224]), 256'(32'h6a09e666));
    take_digest(0);

    // Two-block message, stub one per word.
    stub_word = 32'h1;
    run_block(1'b1, 1'b0, H_INIT, '0);
    run_block(1'b0, 1'b1, add_words(H_INIT, {8{32'h1}}), add_words(add_words(H_INIT, {8{32'h1}}), {8{32'h1}}));
    check("two_block_h0", 256'(digest[255:224]), 256'(32'h6a09e669));
    take_digest(0);

    // Real round function on "abc", with a stalled consumer.
    use_model = 1'b1;
    run_block(1'b1, 1'b1, H_INIT, ABC_DIGEST);
    take_digest(10);
    use_model = 1'b0;

    // Asynchronous reset in the middle of round 30.
    stub_word = 32'h0;
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
    tick();
    blk_valid = 1'b0; blk_first = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    check("pre_reset round_idx", 256'({round_en, round_idx}), 256'({1'b1, 6'd30}));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset {blk_ready,busy,wv_load,round_en,digest_valid}",
          256'({blk_ready, busy, wv_load, round_en, digest_valid}), 256'(5'b10000));
    check("async_reset round_idx", 256'(round_idx), 256'(0));
    check("async_reset hash_state", hash_state, 256'(0));
    tick();
    rst = 1'b0;
    tick();
    check("post_reset idle", 256'({blk_ready, busy, hash_state}), 256'({2'b10, 256'(0)}));
    run_block(1'b0, 1'b1, H_INIT, H_INIT);
    take_digest(0);

    check("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
